irq_scheduler: RTL
==================

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameter NSRC, 4, number of interrupt sources; fixed at 4 in this revision, source 0 = timer int_stb.
REQ-002 clk_z80  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 src_stb  input  4  one-cycle request strobes, clk_z80-synchronous; bit 0 driven by the timer's int_stb.
REQ-005 cfg_wr  input  1  configuration write strobe, one cycle.
REQ-006 cfg_addr  input  2  configuration register select.
REQ-007 cfg_data  input  8  configuration write data.
REQ-008 int_ack  input  1  one-cycle Z80 interrupt-acknowledge strobe (M1 and IORQ qualified externally).
REQ-009 int_n  output  1  Z80 /INT, active low, registered.
REQ-010 vector  output  8  IM2 vector byte, registered.
REQ-011 rate  output  3  timer rate select, registered, fed to the timer's rate input.
REQ-012 pending  output  4  pending flags, readback.
REQ-013 enable  output  4  enable mask, readback.

Function
REQ-014 Registers: addr 0 = enable[3:0]; addr 1 = vec_base from cfg_data[7:3]; addr 2 = rate from cfg_data[2:0]; addr 3 = write-1-to-clear of pending[3:0]; unused data bits ignored.
REQ-015 pending[i] SHALL set on src_stb[i] while enable[i]=1; src_stb[i] with enable[i]=0 is discarded, not remembered.
REQ-016 Set SHALL win over any simultaneous clear (software clear or acknowledge) of the same bit.
REQ-017 Winner = lowest index i with pending[i] & enable[i]; source 0 highest priority.
REQ-018 States: IDLE, ASSERT, GAP; int_n = 0 only in ASSERT.
REQ-019 IDLE -> ASSERT when any pending & enable bit is set; int_n falls on the following edge.
REQ-020 Latency: src_stb high in cycle N -> pending in cycle N+1 -> int_n low in cycle N+2.
REQ-021 ASSERT with int_ack: clear pending[winner], load vector = {vec_base, winner[1:0], 1'b0}, go to GAP.
REQ-022 ASSERT with no pending & enable bits left (software clear or mask change) and no int_ack: return to IDLE, int_n high next edge, vector unchanged.
REQ-023 GAP lasts exactly 2 cycles with int_n high, then IDLE; new requests accumulate in pending during GAP.
REQ-024 int_ack in IDLE or GAP SHALL be ignored: no flag, vector or state change.
REQ-025 int_ack and a software clear in the same ASSERT cycle: the acknowledge uses the winner evaluated before the clear.
REQ-026 A rate write SHALL take effect on the next edge; writes to other registers do not affect rate.

Reset
REQ-027 On rst: state IDLE, int_n = 1, pending = 0, enable = 0, vec_base = 5'b11111, vector = 8'hF8, rate = 3'b000.
REQ-028 rst asserted mid-ASSERT SHALL release int_n immediately (asynchronously) and discard all pending requests.

Structure
REQ-029 Shared package irq_pkg SHALL hold the register address constants, the state encoding and the reset values of vec_base and rate.
REQ-030 Winner selection SHALL be a separate combinational sub-module irq_prio_enc (4-bit request in, 2-bit index plus valid out).

Verification
REQ-031 Reset, enable=4'b0001, pulse src_stb=4'b0001 in cycle N -> pending=4'b0001 at N+1, int_n=0 at N+2; int_ack -> vector=8'hF8, pending=0, int_n high for 2 cycles, then IDLE.
REQ-032 enable=4'b1111, vec_base=5'b10000, src_stb=4'b1010 together -> first ack vector=8'h82; after GAP int_n re-asserts; second ack vector=8'h86.
REQ-033 enable=4'b0000, src_stb=4'b0001 -> pending stays 0 and int_n stays 1; later enable=4'b0001 -> still no interrupt.
REQ-034 In ASSERT with pending=4'b0100, write 8'h04 to addr 3 -> int_n=1 next edge, state IDLE, vector unchanged; a simultaneous src_stb[2] with the clear -> pending[2] stays 1.
REQ-035 Write 8'h05 to addr 2 -> rate=3'b101 next edge; int_ack while IDLE -> no change; rst during ASSERT -> int_n=1 and pending=0 immediately.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : irq_pkg                                                      |
// | Description : Shared definitions for the Z80 IM2 interrupt scheduler:      |
// |               configuration register addresses, FSM state encoding,        |
// |               reset values and a vector-formatting helper.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package irq_pkg;

  // Number of interrupt sources handled by this revision (source 0 = timer)
  localparam int NSRC_DEF = 4;

  // Configuration register map
  localparam logic [1:0] ADDR_ENABLE = 2'd0;  // enable[3:0]
  localparam logic [1:0] ADDR_VBASE  = 2'd1;  // vec_base <= cfg_data[7:3]
  localparam logic [1:0] ADDR_RATE   = 2'd2;  // rate     <= cfg_data[2:0]
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;  // write-1-to-clear pending[3:0]

  // Reset values
  localparam logic [4:0] VEC_BASE_RST = 5'b11111;
  localparam logic [2:0] RATE_RST     = 3'b000;

  // Scheduler states; /INT is driven low only in ST_ASSERT
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // IM2 vector byte: base in the top five bits, source index above a zero LSB
  function automatic logic [7:0] vec_byte(input logic [4:0] base, input logic [1:0] idx);
    return {base, idx, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : irq_scheduler_if                                             |
// | Description : Bundles the request, configuration, Z80 acknowledge and      |
// |               readback signals of irq_scheduler.                           |
// |   src_stb  [3:0] request strobes (bit 0 = timer int_stb)                   |
// |   cfg_wr / cfg_addr[1:0] / cfg_data[7:0]  configuration write port         |
// |   int_ack        Z80 interrupt-acknowledge strobe                          |
// |   int_n          Z80 /INT (active low)                                     |
// |   vector  [7:0]  IM2 vector byte                                           |
// |   rate    [2:0]  timer rate select                                         |
// |   pending [3:0] / enable [3:0]  readback                                   |
// |   Modports: master = system side (drives requests/config), slave = DUT.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface irq_scheduler_if;
  import irq_pkg::*;

  logic [NSRC_DEF-1:0] src_stb;
  logic                cfg_wr;
  logic [1:0]          cfg_addr;
  logic [7:0]          cfg_data;
  logic                int_ack;
  logic                int_n;
  logic [7:0]          vector;
  logic [2:0]          rate;
  logic [NSRC_DEF-1:0] pending;
  logic [NSRC_DEF-1:0] enable;

  modport master (
    output src_stb, cfg_wr, cfg_addr, cfg_data, int_ack,
    input  int_n, vector, rate, pending, enable
  );

  modport slave (
    input  src_stb, cfg_wr, cfg_addr, cfg_data, int_ack,
    output int_n, vector, rate, pending, enable
  );

endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_prio_enc                                                 |
// | Description : Fixed-priority encoder, lowest index wins.                   |
// |   i_req   [3:0] request vector (pending & enable)                          |
// |   o_idx   [1:0] index of the winning request                               |
// |   o_valid       at least one request present                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_prio_enc (
  input  logic [3:0] i_req,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = 2'd0;
    if (i_req[0])      o_idx = 2'd0;
    else if (i_req[1]) o_idx = 2'd1;
    else if (i_req[2]) o_idx = 2'd2;
    else if (i_req[3]) o_idx = 2'd3;
  end

endmodule
`default_nettype wire

// File: rtl/irq_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_scheduler                                                |
// | Description : Z80 IM2 interrupt scheduler. Latches enabled request         |
// |               strobes into pending flags, drives /INT for the highest      |
// |               priority pending source, supplies the IM2 vector on          |
// |               acknowledge, then holds /INT high for a two-cycle gap.       |
// |   clk_z80  sole clock (rising edge)                                        |
// |   rst      asynchronous active-high reset                                  |
// |   bus      irq_scheduler_if.slave (requests, config, ack, outputs)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_scheduler
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic           clk_z80,
  input  logic           rst,
  irq_scheduler_if.slave bus
);

  // Registered state
  state_t            state_q,    state_d;
  logic              gap_cnt_q,  gap_cnt_d;
  logic [NSRC-1:0]   pending_q,  pending_d;
  logic [NSRC-1:0]   enable_q,   enable_d;
  logic [4:0]        vec_base_q, vec_base_d;
  logic [7:0]        vector_q,   vector_d;
  logic [2:0]        rate_q,     rate_d;
  logic              int_n_q,    int_n_d;

  // Combinational helpers
  logic [NSRC-1:0]   w_set;
  logic [NSRC-1:0]   w_sw_clr;
  logic [NSRC-1:0]   w_ack_clr;
  logic [NSRC-1:0]   w_keep;
  logic [1:0]        w_win_idx;
  logic              w_win_valid;

  // Winner is always taken from the flags as they stand this cycle, so an
  // acknowledge coinciding with a software clear still serves the source
  // that was being signalled.
  irq_prio_enc u_prio_enc (
    .i_req   (pending_q & enable_q),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    enable_d   = enable_q;
    vec_base_d = vec_base_q;
    rate_d     = rate_q;
    vector_d   = vector_q;
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    w_ack_clr  = '0;
    w_sw_clr   = '0;

    // Strobes on masked sources are dropped outright
    w_set = bus.src_stb & enable_q;

    if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        ADDR_ENABLE: enable_d   = bus.cfg_data[NSRC-1:0];
        ADDR_VBASE:  vec_base_d = bus.cfg_data[7:3];
        ADDR_RATE:   rate_d     = bus.cfg_data[2:0];
        ADDR_CLEAR:  w_sw_clr   = bus.cfg_data[NSRC-1:0];
        default:     ;
      endcase
    end

    // Flags that survive this cycle ignoring any acknowledge; used to drop
    // /INT on the very next edge when software clears or masks everything.
    w_keep = (pending_q & ~w_sw_clr) | w_set;

    case (state_q)
      ST_IDLE: begin
        if (w_win_valid) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (bus.int_ack && w_win_valid) begin
          w_ack_clr[w_win_idx] = 1'b1;
          vector_d             = vec_byte(vec_base_q, w_win_idx);
          state_d              = ST_GAP;
          gap_cnt_d            = 1'b0;
        end else if (!(|(w_keep & enable_d))) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q) state_d = ST_IDLE;
        else           gap_cnt_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set is ORed last so it wins over either kind of clear
    pending_d = (pending_q & ~w_sw_clr & ~w_ack_clr) | w_set;
    int_n_d   = (state_d != ST_ASSERT);
  end

  always_ff @(posedge clk_z80 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= 1'b0;
      pending_q  <= '0;
      enable_q   <= '0;
      vec_base_q <= VEC_BASE_RST;
      vector_q   <= vec_byte(VEC_BASE_RST, 2'd0);
      rate_q     <= RATE_RST;
      int_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      vec_base_q <= vec_base_d;
      vector_q   <= vector_d;
      rate_q     <= rate_d;
      int_n_q    <= int_n_d;
    end
  end

  assign bus.int_n   = int_n_q;
  assign bus.vector  = vector_q;
  assign bus.rate    = rate_q;
  assign bus.pending = pending_q;
  assign bus.enable  = enable_q;

endmodule
`default_nettype wire
